encoder_rr_arbiter: RTL

ENCODER_RR_ARBITER -- requirements
Module: encoder_rr_arbiter

---
 rtl/encoder_pkg.sv | 25 ++
 rtl/rr_pick.sv | 37 +++
 rtl/encoder_rr_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared constants, FSM state type and a one-hot decode helper for the
// round-robin grant arbiter that feeds the 16-bit one-hot encoder.
package encoder_pkg;

    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // OR-reduction decode; only meaningful for a one-hot (or zero) input.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-search: returns the first set bit of (req & mask)
// at or above ptr, wrapping from the top bit back to bit 0.
module rr_pick
    import encoder_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               found_o
);

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] lowest;

    assign cand    = req_i & mask_i;
    assign found_o = |cand;

    // Rotate so that bit ptr lands at position 0; the 4-bit index sum wraps.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = cand[IDX_W'(i) + ptr_i];
        end
    end

    assign lowest = rot & (~rot + NUM_REQ'(1));

    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_o[IDX_W'(i) + ptr_i] = lowest[i];
        end
    end

endmodule

// File: rtl/encoder_rr_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant with a valid/ready
// handshake. Define ARB_LOCK_EN to add the gnt_lock input (re-grant on fire).
module encoder_rr_arbiter #(
    parameter int NUM_REQ = encoder_pkg::NUM_REQ
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               gnt_ready,
`ifdef ARB_LOCK_EN
    input  logic               gnt_lock,
`endif
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic               gnt_valid
);

    import encoder_pkg::*;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_mask;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_found;
    logic               keep_self;

    assign gnt_idx   = onehot_to_idx(gnt_q);
    assign pick_ptr  = (state_q == GRANT) ? (gnt_idx + IDX_W'(1)) : ptr_q;
    assign pick_mask = (state_q == GRANT) ? ~gnt_q : '1;
    assign keep_self = |(req & gnt_q);

    rr_pick u_rr_pick (
        .req_i   (req),
        .mask_i  (pick_mask),
        .ptr_i   (pick_ptr),
        .gnt_o   (pick_gnt),
        .found_o (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // On fire, other requesters win first; the current holder is re-granted
    // only when it is the sole one still requesting.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_gnt;
                    state_d = GRANT;
                end else begin
                    gnt_d = '0;
                end
            end
            GRANT: begin
                if (gnt_ready) begin
                    ptr_d = pick_ptr;
                    if (pick_found) begin
                        gnt_d = pick_gnt;
                    end else if (keep_self) begin
                        gnt_d = gnt_q;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
`ifdef ARB_LOCK_EN
                    if (gnt_lock && keep_self) begin
                        ptr_d   = ptr_q;
                        gnt_d   = gnt_q;
                        state_d = GRANT;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        gnt_onehot = gnt_q;
        gnt_valid  = (state_q == GRANT);
    end

endmodule
